// File: rtl/add_pkg.sv
// Shared definitions for the adder datapath: FSM state encodings, the sum width
// and a ceiling-log2 helper used to size counters.
package add_pkg;

  localparam int SUM_W_DEF = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/acc_add.sv
// ACC_W-bit unsigned adder returning {carry, sum}; with SUM_ACC_SATURATE_EN
// defined the sum clamps to all-ones whenever a carry occurs.
module acc_add #(
  parameter int ACC_W = 8
) (
  input  logic [ACC_W-1:0] a_i,
  input  logic [ACC_W-1:0] b_i,
  output logic [ACC_W-1:0] sum_o,
  output logic             carry_o
);

  logic [ACC_W:0] full_sum;

  assign full_sum = {1'b0, a_i} + {1'b0, b_i};
  assign carry_o  = full_sum[ACC_W];

`ifdef SUM_ACC_SATURATE_EN
  assign sum_o = full_sum[ACC_W] ? {ACC_W{1'b1}} : full_sum[ACC_W-1:0];
`else
  assign sum_o = full_sum[ACC_W-1:0];
`endif

endmodule

// File: rtl/sum_accumulator.sv
// Accumulates CNT accepted adder sums into one ACC_W-bit total with an overflow flag,
// over valid/ready on both sides. SUM_ACC_SATURATE_EN selects clamping instead of wrap.
module sum_accumulator
  import add_pkg::*;
#(
  parameter int SUM_W = SUM_W_DEF,
  parameter int CNT   = 4,
  parameter int ACC_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SUM_W-1:0] in_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_ovf
);

  localparam int CNT_W = clog2(CNT + 1);

  state_t           state_q;
  logic [ACC_W-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ovf_q;
  logic             in_ready_q;
  logic             out_valid_q;

  logic             beat;
  logic [ACC_W-1:0] add_a;
  logic [ACC_W-1:0] add_b;
  logic [ACC_W-1:0] add_sum;
  logic             add_carry;

  assign beat  = in_valid && in_ready_q;
  // The first beat of a block adds onto zero, so one adder serves both IDLE and ACCUM.
  assign add_a = (state_q == IDLE) ? '0 : acc_q;
  assign add_b = ACC_W'(in_sum);

  acc_add #(.ACC_W(ACC_W)) u_acc_add (
    .a_i    (add_a),
    .b_i    (add_b),
    .sum_o  (add_sum),
    .carry_o(add_carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (beat) begin
            acc_q <= add_sum;
            cnt_q <= CNT_W'(1);
            ovf_q <= 1'b0;
            if (CNT == 1) begin
              state_q     <= DONE;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end else begin
              state_q <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (beat) begin
            acc_q <= add_sum;
            cnt_q <= cnt_q + CNT_W'(1);
            ovf_q <= ovf_q | add_carry;
            if (cnt_q == CNT_W'(CNT - 1)) begin
              state_q     <= DONE;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_acc   = acc_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_sum_accumulator.sv
// Bench for sum_accumulator: an ACC_W=8 and an ACC_W=6 instance (CNT=4) share stimulus
// and are compared against block totals computed from plain integer arithmetic.
module tb_sum_accumulator;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [4:0] in_sum = '0;

  logic       rdy8, ov8, ovf8;
  logic [7:0] acc8;
  logic       rdy6, ov6, ovf6;
  logic [5:0] acc6;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sum_accumulator #(.SUM_W(5), .CNT(4), .ACC_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy8), .in_sum(in_sum),
    .out_valid(ov8), .out_ready(out_ready), .out_acc(acc8), .out_ovf(ovf8)
  );

  sum_accumulator #(.SUM_W(5), .CNT(4), .ACC_W(6)) dut6 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy6), .in_sum(in_sum),
    .out_valid(ov6), .out_ready(out_ready), .out_acc(acc6), .out_ovf(ovf6)
  );

  // {out_valid, in_ready, out_ovf, out_acc}
  wire [10:0] st8 = {ov8, rdy8, ovf8, acc8};
  wire [8:0]  st6 = {ov6, rdy6, ovf6, acc6};

  // Reference: true block total, then wrap or clamp into w bits.
  function automatic int m_acc(input int total, input int w);
    int lim;
    lim = 1 << w;
    if (total < lim) return total;
`ifdef SUM_ACC_SATURATE_EN
    return lim - 1;
`else
    return total % lim;
`endif
  endfunction

  function automatic logic m_ovf(input int total, input int w);
    return total >= (1 << w);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid  = 1'($urandom);
      in_sum    = 5'($urandom);
      out_ready = 1'($urandom);
      tick();
      checks++;
      if (st8 !== {1'b0, 1'b1, 1'b0, 8'd0}) begin
        errors++;
        $display("FAIL reset_w8 got v/r/ovf/acc=%h want %h", st8, {1'b0, 1'b1, 1'b0, 8'd0});
      end
      checks++;
      if (st6 !== {1'b0, 1'b1, 1'b0, 6'd0}) begin
        errors++;
        $display("FAIL reset_w6 got v/r/ovf/acc=%h want %h", st6, {1'b0, 1'b1, 1'b0, 6'd0});
      end
    end
    in_valid = 1'b0;
    rst_n    = 1'b1;
    tick();
    $display("reset released");
  endtask

  task automatic test_basic();
    int vals[4] = '{2, 3, 4, 5};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_sum   = 5'(vals[i]);
      tick();
      if (i < 3) begin
        checks++;
        if ({ov8, rdy8, ov6, rdy6} !== 4'b0101) begin
          errors++;
          $display("FAIL basic_accum got v8/r8/v6/r6=%b want 0101", {ov8, rdy8, ov6, rdy6});
        end
      end
    end
    in_valid = 1'b0;
    checks++;
    if (st8 !== {1'b1, 1'b0, 1'b0, 8'd14}) begin
      errors++;
      $display("FAIL basic_w8 got %h want %h", st8, {1'b1, 1'b0, 1'b0, 8'd14});
    end
    checks++;
    if (st6 !== {1'b1, 1'b0, 1'b0, 6'd14}) begin
      errors++;
      $display("FAIL basic_w6 got %h want %h", st6, {1'b1, 1'b0, 1'b0, 6'd14});
    end
    $display("block basic acc8=%0d acc6=%0d", acc8, acc6);
    tick();
    checks++;
    if ({ov8, rdy8, ov6, rdy6} !== 4'b0101) begin
      errors++;
      $display("FAIL basic_idle got v8/r8/v6/r6=%b want 0101", {ov8, rdy8, ov6, rdy6});
    end
  endtask

  task automatic test_backpressure();
    int total = 0;
    logic [10:0] e8;
    logic [8:0]  e6;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_sum   = 5'($urandom);
      total   += int'(in_sum);
      tick();
    end
    e8 = {1'b1, 1'b0, m_ovf(total, 8), 8'(m_acc(total, 8))};
    e6 = {1'b1, 1'b0, m_ovf(total, 6), 6'(m_acc(total, 6))};
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_sum   = 5'($urandom);
      checks++;
      if (st8 !== e8) begin
        errors++;
        $display("FAIL bp_hold_w8 cycle %0d got %h want %h", i, st8, e8);
      end
      checks++;
      if (st6 !== e6) begin
        errors++;
        $display("FAIL bp_hold_w6 cycle %0d got %h want %h", i, st6, e6);
      end
      tick();
    end
    $display("block backpressure total=%0d acc8=%0d acc6=%0d", total, acc8, acc6);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    checks++;
    if ({ov8, rdy8, ov6, rdy6} !== 4'b0101) begin
      errors++;
      $display("FAIL bp_release got v8/r8/v6/r6=%b want 0101", {ov8, rdy8, ov6, rdy6});
    end
  endtask

  task automatic test_overflow();
    logic [5:0] want6;
`ifdef SUM_ACC_SATURATE_EN
    want6 = 6'd63;
`else
    want6 = 6'd60;
`endif
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_sum   = 5'd31;
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (st6 !== {1'b1, 1'b0, 1'b1, want6}) begin
      errors++;
      $display("FAIL ovf_w6 got %h want %h", st6, {1'b1, 1'b0, 1'b1, want6});
    end
    checks++;
    if (st8 !== {1'b1, 1'b0, 1'b0, 8'd124}) begin
      errors++;
      $display("FAIL ovf_w8 got %h want %h", st8, {1'b1, 1'b0, 1'b0, 8'd124});
    end
    $display("block overflow acc8=%0d ovf8=%b acc6=%0d ovf6=%b", acc8, ovf8, acc6, ovf6);
    tick();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_sum   = 5'($urandom_range(31, 1));
      tick();
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (st8 !== {1'b0, 1'b1, 1'b0, 8'd0}) begin
      errors++;
      $display("FAIL midrst_async got %h want %h", st8, {1'b0, 1'b1, 1'b0, 8'd0});
    end
    tick();
    in_valid = 1'b0;
    rst_n    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_sum   = 5'd1;
      tick();
      if (i < 3) begin
        checks++;
        if ({ov8, ov6} !== 2'b00) begin
          errors++;
          $display("FAIL midrst_early_valid beat %0d got %b want 00", i, {ov8, ov6});
        end
      end
    end
    in_valid = 1'b0;
    checks++;
    if (st8 !== {1'b1, 1'b0, 1'b0, 8'd4}) begin
      errors++;
      $display("FAIL midrst_w8 got %h want %h", st8, {1'b1, 1'b0, 1'b0, 8'd4});
    end
    checks++;
    if (st6 !== {1'b1, 1'b0, 1'b0, 6'd4}) begin
      errors++;
      $display("FAIL midrst_w6 got %h want %h", st6, {1'b1, 1'b0, 1'b0, 6'd4});
    end
    $display("block after reset acc8=%0d", acc8);
    tick();
  endtask

  task automatic test_gapped();
    int vals[4] = '{7, 9, 11, 13};
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      in_valid = (i % 2 == 0);
      in_sum   = (i % 2 == 0) ? 5'(vals[i/2]) : 5'($urandom);
      tick();
      if (i < 6) begin
        checks++;
        if ({ov8, ov6} !== 2'b00) begin
          errors++;
          $display("FAIL gap_early_valid cycle %0d got %b want 00", i, {ov8, ov6});
        end
      end
    end
    in_valid = 1'b0;
    checks++;
    if (st8 !== {1'b1, 1'b0, 1'b0, 8'd40}) begin
      errors++;
      $display("FAIL gap_w8 got %h want %h", st8, {1'b1, 1'b0, 1'b0, 8'd40});
    end
    checks++;
    if (st6 !== {1'b1, 1'b0, 1'b0, 6'd40}) begin
      errors++;
      $display("FAIL gap_w6 got %h want %h", st6, {1'b1, 1'b0, 1'b0, 6'd40});
    end
    $display("block gapped acc8=%0d", acc8);
    tick();
  endtask

  task automatic test_random();
    int          beats[$];
    bit          pending = 0;
    int          blocks = 0;
    int          cycles = 0;
    int          total = 0;
    logic        iv, ordy;
    logic [4:0]  s;
    logic [10:0] e8;
    logic [8:0]  e6;
    while (blocks < 25 && cycles < 3000) begin
      iv        = ($urandom % 4) != 0;
      s         = 5'($urandom);
      ordy      = ($urandom % 3) != 0;
      in_valid  = iv;
      in_sum    = s;
      out_ready = ordy;
      tick();
      cycles++;
      if (pending) begin
        if (ordy) pending = 0;
      end else if (iv) begin
        beats.push_back(int'(s));
        if (beats.size() == 4) begin
          total = 0;
          foreach (beats[k]) total += beats[k];
          beats.delete();
          pending = 1;
          blocks++;
          $display("block random %0d total=%0d exp8=%0d exp6=%0d", blocks, total,
                   m_acc(total, 8), m_acc(total, 6));
        end
      end
      e8 = {pending, !pending, m_ovf(total, 8), 8'(m_acc(total, 8))};
      e6 = {pending, !pending, m_ovf(total, 6), 6'(m_acc(total, 6))};
      checks++;
      if (pending ? (st8 !== e8) : (st8[10:9] !== e8[10:9])) begin
        errors++;
        $display("FAIL rand_w8 cycle %0d got %h want %h", cycles, st8, e8);
      end
      checks++;
      if (pending ? (st6 !== e6) : (st6[8:7] !== e6[8:7])) begin
        errors++;
        $display("FAIL rand_w6 cycle %0d got %h want %h", cycles, st6, e6);
      end
    end
    checks++;
    if (blocks < 25) begin
      errors++;
      $display("FAIL rand_timeout got %0d blocks want 25", blocks);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_overflow();
    test_reset_mid();
    test_gapped();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
